// File: rtl/insn_prefetch.sv
// Instruction prefetcher: sequential Avalon-MM word fetch into a DEPTH-entry FIFO feeding decode.
// Optional performance counters are enabled with `define INSN_PREFETCH_PERF_EN.
module insn_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic [31:0] avl_insn_address,
    output logic        avl_insn_read,
    input  logic        avl_insn_waitrequest,
    input  logic [31:0] avl_insn_readdata,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    input  logic        insn_ready
`ifdef INSN_PREFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_discards
`endif
);

    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Bit 0 of the encoding is the bus read request, so the read strobe is a flop output.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FETCH   = 2'b01,
        DISCARD = 2'b11
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next, addr_q;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          completion, push, pop, fetch_keep;

    assign completion = avl_insn_read && !avl_insn_waitrequest;
    assign push       = fetch_keep && completion && !flush;
    assign pop        = insn_valid && insn_ready && !flush;
    assign count_next = flush ? '0 : count + CW'(push) - CW'(pop);

    assign insn_valid       = (count != '0);
    assign insn             = mem_data[rd_ptr];
    assign insn_pc          = mem_pc[rd_ptr];
    assign avl_insn_address = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flush || (count_next < DEPTH_C)) state_next = FETCH;
            end
            FETCH: begin
                if (flush) begin
                    state_next = completion ? FETCH : DISCARD;
                end else if (completion && !(count_next < DEPTH_C)) begin
                    state_next = IDLE;
                end
            end
            DISCARD: begin
                // The stale read must finish first; fetch_pc already holds the target.
                if (completion) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        avl_insn_read = state[0];
        fetch_keep    = (state == FETCH);
    end

    always_comb begin
        fetch_pc_next = fetch_pc;
        if (flush) begin
            fetch_pc_next = flush_target & 32'hFFFF_FFFC;
        end else if (push) begin
            fetch_pc_next = fetch_pc + 32'd4;
        end
    end

    // NOTE: the FIFO storage is reset because insn/insn_pc come straight from the head
    // entry and must read zero out of reset; at this depth the cost is a handful of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
            // The address of a read being discarded stays on the bus until it completes.
            if (state_next != DISCARD) addr_q <= fetch_pc_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem_data[wr_ptr] <= avl_insn_readdata;
                    mem_pc[wr_ptr]   <= fetch_pc;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef INSN_PREFETCH_PERF_EN
    logic drop;
    assign drop = completion && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches  <= '0;
            perf_discards <= '0;
        end else begin
            if (push && (perf_fetches != 32'hFFFF_FFFF)) perf_fetches <= perf_fetches + 32'd1;
            if (drop && (perf_discards != 32'hFFFF_FFFF)) perf_discards <= perf_discards + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_insn_prefetch.sv
// Self-checking bench for insn_prefetch: directed scenarios plus a randomized run against
// a queue-based model of the fetch stream.
module tb_insn_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_target;
    logic [31:0] avl_insn_address;
    logic        avl_insn_read;
    logic        avl_insn_waitrequest;
    logic [31:0] avl_insn_readdata;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready;
`ifdef INSN_PREFETCH_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_discards;
`endif

    insn_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .flush                (flush),
        .flush_target         (flush_target),
        .avl_insn_address     (avl_insn_address),
        .avl_insn_read        (avl_insn_read),
        .avl_insn_waitrequest (avl_insn_waitrequest),
        .avl_insn_readdata    (avl_insn_readdata),
        .insn                 (insn),
        .insn_pc              (insn_pc),
        .insn_valid           (insn_valid),
        .insn_ready           (insn_ready)
`ifdef INSN_PREFETCH_PERF_EN
        ,
        .perf_fetches         (perf_fetches),
        .perf_discards        (perf_discards)
`endif
    );

    always #5 clk = ~clk;

    // Slave returns a word derived from the address so every entry is traceable.
    assign avl_insn_readdata = avl_insn_address ^ KEY;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the words decode should see, in order, and the address the next kept read must use.
    logic [31:0] m_q[$];
    logic [31:0] m_next;
    bit          m_taint;
    bit          stall_prev;
    logic [31:0] addr_prev;
    int unsigned m_kept;
    int unsigned m_drop;

    task automatic apply_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        flush_target = '0;
        insn_ready = 1'b0;
        avl_insn_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        m_q.delete();
        m_next = RESET_PC;
        m_taint = 1'b0;
        stall_prev = 1'b0;
        m_kept = 0;
        m_drop = 0;
        rst_n = 1'b1;
    endtask

    // One clock: compare outputs with the model, drive inputs, advance the model and the clock.
    task automatic step(input logic f, input logic [31:0] tgt, input logic rdy, input logic w);
        logic comp, kept, popm;
        n_checks++;
        if (insn_valid !== (m_q.size() != 0)) begin
            n_fail++;
            $display("FAIL valid: got %b want %b", insn_valid, (m_q.size() != 0));
        end
        if (m_q.size() != 0) begin
            n_checks++;
            if (insn_pc !== m_q[0] || insn !== (m_q[0] ^ KEY)) begin
                n_fail++;
                $display("FAIL head: got pc=%h insn=%h want pc=%h insn=%h",
                         insn_pc, insn, m_q[0], m_q[0] ^ KEY);
            end
        end
        if (stall_prev) begin
            n_checks++;
            if (avl_insn_read !== 1'b1 || avl_insn_address !== addr_prev) begin
                n_fail++;
                $display("FAIL stall_hold: got read=%b addr=%h want read=1 addr=%h",
                         avl_insn_read, avl_insn_address, addr_prev);
            end
        end

        flush = f;
        flush_target = tgt;
        insn_ready = rdy;
        avl_insn_waitrequest = w;

        comp = avl_insn_read && !w;
        kept = comp && !f && !m_taint;
        popm = (m_q.size() != 0) && rdy && !f;
        if (comp && !kept) m_drop++;
        if (f) begin
            m_taint = avl_insn_read && !comp;
            m_q.delete();
            m_next = tgt & 32'hFFFF_FFFC;
        end else begin
            if (comp) m_taint = 1'b0;
            if (popm) void'(m_q.pop_front());
            if (kept) begin
                n_checks++;
                if (avl_insn_address !== m_next) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got %h want %h", avl_insn_address, m_next);
                end
                m_q.push_back(m_next);
                m_next = m_next + 32'd4;
                m_kept++;
                n_checks++;
                if (m_q.size() > DEPTH) begin
                    n_fail++;
                    $display("FAIL overflow: got %0d entries want <= %0d", m_q.size(), DEPTH);
                end
            end
        end
        stall_prev = avl_insn_read && w;
        addr_prev = avl_insn_address;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to_addr(input logic [31:0] a);
        int k = 0;
        while (!(avl_insn_read === 1'b1 && avl_insn_address === a) && k < 32) begin
            step(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        n_checks++;
        if (k >= 32) begin
            n_fail++;
            $display("FAIL reach_addr: got addr=%h want %h", avl_insn_address, a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        flush_target = '0;
        insn_ready = 1'b0;
        avl_insn_waitrequest = 1'b0;
        @(negedge clk);
        n_checks++;
        if (avl_insn_read !== 1'b0 || insn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got read=%b valid=%b want 0 0", avl_insn_read, insn_valid);
        end
        n_checks++;
        if (avl_insn_address !== RESET_PC || insn !== 32'h0 || insn_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h insn=%h pc=%h want %h 0 0",
                     avl_insn_address, insn, insn_pc, RESET_PC);
        end
        apply_reset();
    endtask

    task automatic test_stream();
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (avl_insn_read !== 1'b1 || avl_insn_address !== RESET_PC || insn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_read: got read=%b addr=%h valid=%b want 1 %h 0",
                     avl_insn_read, avl_insn_address, insn_valid, RESET_PC);
        end
        for (int k = 2; k < 14; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (insn_valid !== 1'b1 || insn_pc !== RESET_PC + 32'(4 * (k - 2))) begin
                n_fail++;
                $display("FAIL stream_pc: got valid=%b pc=%h want 1 %h",
                         insn_valid, insn_pc, RESET_PC + 32'(4 * (k - 2)));
            end
        end
    endtask

    task automatic test_backpressure();
        int comps = 0;
        int j = 0;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            if (avl_insn_read === 1'b1) comps++;
            step(1'b0, '0, 1'b0, 1'b0);
        end
        n_checks++;
        if (comps != DEPTH || avl_insn_read !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stop: got comps=%0d read=%b want %0d 0", comps, avl_insn_read, DEPTH);
        end
        for (int k = 0; k < 12; k++) begin
            if (insn_valid === 1'b1) begin
                n_checks++;
                if (insn_pc !== RESET_PC + 32'(4 * j)) begin
                    n_fail++;
                    $display("FAIL resume_pc: got %h want %h", insn_pc, RESET_PC + 32'(4 * j));
                end
                j++;
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (j < 8) begin
            n_fail++;
            $display("FAIL resume_count: got %0d want >= 8", j);
        end
    endtask

    task automatic test_waitstate();
        apply_reset();
        run_to_addr(RESET_PC + 32'h8);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            n_checks++;
            if (avl_insn_read !== 1'b1 || avl_insn_address !== RESET_PC + 32'h8 || insn_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold: got read=%b addr=%h valid=%b want 1 %h 0",
                         avl_insn_read, avl_insn_address, insn_valid, RESET_PC + 32'h8);
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (insn_valid !== 1'b1 || insn_pc !== RESET_PC + 32'h8) begin
            n_fail++;
            $display("FAIL wait_push: got valid=%b pc=%h want 1 %h", insn_valid, insn_pc, RESET_PC + 32'h8);
        end
    endtask

    task automatic test_flush_stall();
        apply_reset();
        run_to_addr(RESET_PC + 32'h8);
        step(1'b1, 32'h0000_1003, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (avl_insn_read !== 1'b1 || avl_insn_address !== RESET_PC + 32'h8 || insn_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL discard_hold: got read=%b addr=%h valid=%b want 1 %h 0",
                         avl_insn_read, avl_insn_address, insn_valid, RESET_PC + 32'h8);
            end
            step(1'b0, '0, 1'b1, (k < 3) ? 1'b1 : 1'b0);
        end
        n_checks++;
        if (avl_insn_read !== 1'b1 || avl_insn_address !== 32'h0000_1000 || insn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect: got read=%b addr=%h valid=%b want 1 00001000 0",
                     avl_insn_read, avl_insn_address, insn_valid);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (insn_valid !== 1'b1 || insn_pc !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL redirect_head: got valid=%b pc=%h want 1 00001000", insn_valid, insn_pc);
        end
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush_complete();
        apply_reset();
        run_to_addr(RESET_PC + 32'h8);
        step(1'b1, 32'h0000_2000, 1'b1, 1'b0);
        n_checks++;
        if (insn_valid !== 1'b0 || avl_insn_read !== 1'b1 || avl_insn_address !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL flush_comp: got valid=%b read=%b addr=%h want 0 1 00002000",
                     insn_valid, avl_insn_read, avl_insn_address);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (insn_valid !== 1'b1 || insn_pc !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL flush_comp_head: got valid=%b pc=%h want 1 00002000", insn_valid, insn_pc);
        end
    endtask

    task automatic test_reset_midstall();
        apply_reset();
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (avl_insn_read !== 1'b0 || insn_valid !== 1'b0 || avl_insn_address !== RESET_PC ||
            insn_pc !== 32'h0 || insn !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got read=%b valid=%b addr=%h pc=%h insn=%h want 0 0 %h 0 0",
                     avl_insn_read, insn_valid, avl_insn_address, insn_pc, insn, RESET_PC);
        end
`ifdef INSN_PREFETCH_PERF_EN
        n_checks++;
        if (perf_fetches !== 32'h0 || perf_discards !== 32'h0) begin
            n_fail++;
            $display("FAIL perf_reset: got %h %h want 0 0", perf_fetches, perf_discards);
        end
`endif
        apply_reset();
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (avl_insn_read !== 1'b1 || avl_insn_address !== RESET_PC) begin
            n_fail++;
            $display("FAIL restart: got read=%b addr=%h want 1 %h", avl_insn_read, avl_insn_address, RESET_PC);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (insn_valid !== 1'b1 || insn_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL restart_head: got valid=%b pc=%h want 1 %h", insn_valid, insn_pc, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic f, rdy, w;
        apply_reset();
        for (int k = 0; k < 800; k++) begin
            f   = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0) || (k % 100 > 80);
            rdy = rdy && !((k % 100) inside {[30:45]});
            w   = ($urandom_range(0, 2) == 0);
            step(f, $urandom, rdy, w);
        end
        n_checks++;
        if (m_kept < 100) begin
            n_fail++;
            $display("FAIL random_progress: got %0d kept words want >= 100", m_kept);
        end
`ifdef INSN_PREFETCH_PERF_EN
        n_checks++;
        if (perf_fetches !== 32'(m_kept) || perf_discards !== 32'(m_drop)) begin
            n_fail++;
            $display("FAIL perf_count: got %0d %0d want %0d %0d", perf_fetches, perf_discards, m_kept, m_drop);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_waitstate();
        test_flush_stall();
        test_flush_complete();
        test_reset_midstall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
